// File: rtl/hamming_secded_decoder_pipe.sv
// hamming_secded_decoder_pipe
// Two-stage SEC-DED decoder for the 13-bit Hamming(12,8) + overall-parity
// codeword on a valid/ready stream.
//   Stage 1 registers the syndrome, the overall parity and the raw code.
//   Stage 2 classifies the word, corrects single errors and registers the result.
// Optional build macro SECDED_ERR_CNT_EN adds saturating single/double error
// counters. Without it the counters read 0 and cnt_clr is ignored.
// Code layout: bit 0 is overall parity. Bits [12:1] are Hamming positions 1..12.
// Parity bits sit at positions 1/2/4/8. Data d0..d7 sit at positions
// 3,5,6,7,9,10,11,12.
module hamming_secded_decoder_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [12:0] in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_single_err,
  output logic        out_double_err,
  output logic [3:0]  out_syndrome,
  input  logic        cnt_clr,
  output logic [15:0] single_cnt,
  output logic [15:0] double_cnt
);

  // Hamming position of data bit i
  function automatic logic [3:0] f_dpos(input int i);
    logic [3:0] p;
    case (i)
      0: p = 4'd3;
      1: p = 4'd5;
      2: p = 4'd6;
      3: p = 4'd7;
      4: p = 4'd9;
      5: p = 4'd10;
      6: p = 4'd11;
      default: p = 4'd12;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] f_extract(input logic [12:0] c);
    return {c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
  endfunction

  // ---------------- handshake ----------------
  logic r_s1_valid;
  logic r_out_valid;
  logic w_adv1, w_adv2;

  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  // ---------------- stage 1: syndrome / parity ----------------
  logic [3:0]  w_syn;
  logic        w_par;
  logic [12:0] r_s1_code;
  logic [3:0]  r_s1_syn;
  logic        r_s1_par;

  // Each syndrome bit is the XOR of the positions whose index has that bit set.
  assign w_syn[0] = ^{in_code[1], in_code[3], in_code[5], in_code[7], in_code[9], in_code[11]};
  assign w_syn[1] = ^{in_code[2], in_code[3], in_code[6], in_code[7], in_code[10], in_code[11]};
  assign w_syn[2] = ^{in_code[4], in_code[5], in_code[6], in_code[7], in_code[12]};
  assign w_syn[3] = ^{in_code[8], in_code[9], in_code[10], in_code[11], in_code[12]};
  assign w_par    = ^in_code;

  // Stage 1 valid: the slot moves whenever stage 2 can take its content.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_s1_valid <= 1'b0;
    else if (w_adv1) r_s1_valid <= in_valid;
  end

  // Stage 1 payload: loaded only on an accepted word. Otherwise it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_code <= '0;
      r_s1_syn  <= '0;
      r_s1_par  <= 1'b0;
    end else if (in_valid && w_adv1) begin
      r_s1_code <= in_code;
      r_s1_syn  <= w_syn;
      r_s1_par  <= w_par;
    end
  end

  // Parity positions carry no information once s and p are known.
  logic w_unused_par_bits;
  assign w_unused_par_bits = ^{r_s1_code[8], r_s1_code[4], r_s1_code[2],
                               r_s1_code[1], r_s1_code[0]};

  // ---------------- stage 2: classify / correct ----------------
  logic       w_single, w_double, w_fix_en;
  logic [7:0] w_flip, w_data;

  // Classification from (p, s). Only a data position is worth flipping.
  // A flipped parity position leaves the data unchanged.
  always_comb begin
    w_single = 1'b0;
    w_double = 1'b0;
    w_fix_en = 1'b0;
    if (r_s1_par) begin
      if (r_s1_syn == 4'd0) begin
        w_single = 1'b1;
      end else if (r_s1_syn <= 4'd12) begin
        w_single = 1'b1;
        w_fix_en = 1'b1;
      end else begin
        w_double = 1'b1;
      end
    end else if (r_s1_syn != 4'd0) begin
      w_double = 1'b1;
    end
  end

  // Correction mask over the data bits, then the corrected byte.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 8; i++)
      w_flip[i] = w_fix_en && (r_s1_syn == f_dpos(i));
    w_data = f_extract(r_s1_code) ^ w_flip;
  end

  logic [7:0] r_out_data;
  logic       r_single, r_double;
  logic [3:0] r_syn;

  // Output valid: drops only when the sink consumes and stage 1 is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_out_valid <= 1'b0;
    else if (w_adv2) r_out_valid <= r_s1_valid;
  end

  // Output payload: frozen while stalled, so the sink sees stable data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data <= '0;
      r_single   <= 1'b0;
      r_double   <= 1'b0;
      r_syn      <= '0;
    end else if (r_s1_valid && w_adv2) begin
      r_out_data <= w_data;
      r_single   <= w_single;
      r_double   <= w_double;
      r_syn      <= r_s1_syn;
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_single_err = r_single;
  assign out_double_err = r_double;
  assign out_syndrome   = r_syn;

  // ---------------- error-event counters ----------------
`ifdef SECDED_ERR_CNT_EN
  logic [15:0] r_single_cnt, r_double_cnt;
  logic        w_fire;

  // A word counts on the output handshake only. A stalled word is counted once.
  assign w_fire = r_out_valid && out_ready;

  // Single-error counter: clear wins over increment, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_single_cnt <= '0;
    else if (cnt_clr)
      r_single_cnt <= '0;
    else if (w_fire && r_single && (r_single_cnt != 16'hFFFF))
      r_single_cnt <= r_single_cnt + 16'd1;
  end

  // Double-error counter: same rules as the single-error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_double_cnt <= '0;
    else if (cnt_clr)
      r_double_cnt <= '0;
    else if (w_fire && r_double && (r_double_cnt != 16'hFFFF))
      r_double_cnt <= r_double_cnt + 16'd1;
  end

  assign single_cnt = r_single_cnt;
  assign double_cnt = r_double_cnt;
`else
  logic w_unused_cnt_clr;
  assign w_unused_cnt_clr = cnt_clr;
  assign single_cnt       = '0;
  assign double_cnt       = '0;
`endif

endmodule
